piso_tx_ctrl: RTL and testbench
===============================

PISO_TX_CTRL -- requirements
Module: piso_tx_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the parallel word width in bits (legal range 2..32).
REQ-002 The block SHALL have parameter GAP, default 1, giving the number of idle cycles inserted after each frame (legal range 0..15).
REQ-003 The block SHALL have parameter MSB_FIRST, default 1: 1 means bit WIDTH-1 is sent first, 0 means bit 0 is sent first.
REQ-004 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-005 clk  input  1  rising-edge clock for all state.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 in_data  input  WIDTH  parallel word; sampled only on an accept edge.
REQ-008 in_valid  input  1  requester has a word in in_data.
REQ-009 in_ready  output  1  block can accept a word this cycle.
REQ-010 ser_q  output  1  serial data bit.
REQ-011 ser_valid  output  1  ser_q carries a frame bit this cycle.
REQ-012 frame_start  output  1  high during the first bit of a frame.
REQ-013 frame_done  output  1  high during the last bit of a frame.
REQ-014 busy  output  1  high in SHIFT or GAP.

Function
REQ-015 The FSM SHALL have three states: IDLE, SHIFT and GAP.
REQ-016 An accept SHALL occur on a rising edge where in_valid and in_ready are both high; in_valid without in_ready SHALL be ignored.
REQ-017 On accept, the block SHALL load in_data into the shift register, clear the bit counter and enter SHIFT.
REQ-018 The first bit SHALL be visible in the cycle after the accept edge (latency 1 cycle).
REQ-019 In SHIFT, one bit SHALL be output per cycle for exactly WIDTH cycles, advancing on each edge.
REQ-020 frame_start SHALL be high when counter==0; frame_done SHALL be high when counter==WIDTH-1; both SHALL be qualified by SHIFT.
REQ-021 After the last bit, the FSM SHALL enter GAP if GAP>0, otherwise IDLE.
REQ-022 GAP SHALL last exactly GAP cycles, with ser_valid=0 and ser_q=0, and SHALL then return to IDLE.
REQ-023 in_ready SHALL be high in IDLE; it SHALL also be high in the last SHIFT cycle when GAP==0, so back-to-back frames have no idle cycle; it SHALL be low otherwise.
REQ-024 ser_q, ser_valid, frame_start, frame_done, busy and in_ready SHALL depend only on registered state, with no combinational path from inputs.
REQ-025 Outside SHIFT, ser_q SHALL be 0.
REQ-026 The bit counter SHALL be max(1, $clog2(WIDTH)) bits wide and SHALL never exceed WIDTH-1.
REQ-027 The GAP counter SHALL be 4 bits wide.
REQ-028 Changes to in_data after an accept SHALL NOT affect the frame in flight.

Reset
REQ-029 While rst_n is low, the block SHALL be in IDLE, and the shift register and counters SHALL be 0.
REQ-030 While rst_n is low, in_ready, ser_q, ser_valid, frame_start, frame_done and busy SHALL all be 0.
REQ-031 in_ready SHALL rise in the first cycle after rst_n deasserts.
REQ-032 An assertion of rst_n mid-frame SHALL abort the frame immediately (asynchronously), with no frame_done pulse.

Structure
REQ-033 State encodings (IDLE=0, SHIFT=1, GAP=2) SHALL reside in shared package piso_pkg.
REQ-034 The shift register SHALL be a sub-module, piso_shreg, with ports load, shift, d, q and parameters WIDTH and MSB_FIRST.
REQ-035 The FSM, bit counter and GAP counter SHALL reside in piso_tx_ctrl.

Verification (WIDTH=4 unless stated)
REQ-036 GAP=1, MSB_FIRST=1, accept 4'b1011 -> ser_q 1,0,1,1 on cycles 1-4; frame_start on cycle 1; frame_done on cycle 4; in_ready low for cycles 1-5, high on cycle 6.
REQ-037 MSB_FIRST=0, accept 4'b1011 -> ser_q 1,1,0,1.
REQ-038 GAP=0, in_valid held high with words 4'b1100 then 4'b0011 -> 8 contiguous ser_valid cycles with ser_q 1,1,0,0,0,0,1,1; two frame_start and two frame_done pulses.
REQ-039 in_valid pulsed during SHIFT with 4'b1111 -> word ignored; current frame unchanged; no second frame.
REQ-040 rst_n low at frame bit 2 -> all outputs 0 at once with no frame_done; after release, accept 4'b0110 -> frame 0,1,1,0.

Source files
------------

// File: rtl/piso_pkg.sv
// Shared types and helpers for the parallel-in/serial-out transmit controller.
// State encodings are fixed so that debug probes and other blocks agree on them.
package piso_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } piso_state_t;

    localparam int GAP_CNT_W = 4;

    // Bit counter width: enough to hold WIDTH-1, never narrower than one bit.
    function automatic int cnt_width(input int width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/piso_tx_ctrl_if.sv
// Word handshake plus serial output bundle of the PISO transmit controller.
interface piso_tx_ctrl_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic             ser_q;
    logic             ser_valid;
    logic             frame_start;
    logic             frame_done;
    logic             busy;

    modport master (
        output in_data, in_valid,
        input  in_ready, ser_q, ser_valid, frame_start, frame_done, busy
    );

    modport slave (
        input  in_data, in_valid,
        output in_ready, ser_q, ser_valid, frame_start, frame_done, busy
    );
endinterface

// File: rtl/piso_shreg.sv
// Loadable shift register; zeros are shifted in, so once a frame has fully
// drained q is 0 without any extra gating.
module piso_shreg #(
    parameter int WIDTH     = 4,
    parameter int MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] d,
    output logic             q
);

    logic [WIDTH-1:0] data_reg;
    logic [WIDTH-1:0] shifted;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            if (MSB_FIRST != 0) begin : g_msb
                if (gi == 0) begin : g_fill
                    assign shifted[gi] = 1'b0;
                end else begin : g_move
                    assign shifted[gi] = data_reg[gi-1];
                end
            end else begin : g_lsb
                if (gi == WIDTH - 1) begin : g_fill
                    assign shifted[gi] = 1'b0;
                end else begin : g_move
                    assign shifted[gi] = data_reg[gi+1];
                end
            end
        end
    endgenerate

    // Load wins over shift so a back-to-back word replaces the drained frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_reg <= '0;
        end else if (load) begin
            data_reg <= d;
        end else if (shift) begin
            data_reg <= shifted;
        end
    end

    assign q = (MSB_FIRST != 0) ? data_reg[WIDTH-1] : data_reg[0];

endmodule

// File: rtl/piso_tx_ctrl.sv
// PISO transmit controller: accepts a parallel word, shifts it out one bit per
// cycle with frame markers, then inserts GAP idle cycles before the next word.
module piso_tx_ctrl
    import piso_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int GAP       = 1,
    parameter int MSB_FIRST = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    piso_tx_ctrl_if.slave  bus
);

    localparam int                   CW       = cnt_width(WIDTH);
    localparam logic [CW-1:0]        CNT_LAST = CW'(WIDTH - 1);
    localparam bit                   HAS_GAP  = (GAP > 0);
    localparam logic [GAP_CNT_W-1:0] GAP_LAST = HAS_GAP ? GAP_CNT_W'(GAP - 1) : '0;

    piso_state_t          state_reg;
    logic [CW-1:0]        bit_cnt_reg;
    logic [GAP_CNT_W-1:0] gap_cnt_reg;
    logic                 in_ready_reg;
    logic                 ser_valid_reg;
    logic                 frame_start_reg;
    logic                 frame_done_reg;
    logic                 busy_reg;

    logic                 accept;
    logic                 shift_en;
    logic                 last_bit;
    logic [CW-1:0]        bit_cnt_inc;
    logic                 ser_bit;

    assign accept      = bus.in_valid & in_ready_reg;
    assign shift_en    = (state_reg == ST_SHIFT);
    assign last_bit    = (bit_cnt_reg == CNT_LAST);
    assign bit_cnt_inc = bit_cnt_reg + CW'(1);

    piso_shreg #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_shreg (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (accept),
        .shift (shift_en),
        .d     (bus.in_data),
        .q     (ser_bit)
    );

    // Outputs are registered with the state, so each branch sets the values
    // that belong to the state being entered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= ST_IDLE;
            bit_cnt_reg     <= '0;
            gap_cnt_reg     <= '0;
            in_ready_reg    <= 1'b0;
            ser_valid_reg   <= 1'b0;
            frame_start_reg <= 1'b0;
            frame_done_reg  <= 1'b0;
            busy_reg        <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (accept) begin
                        state_reg       <= ST_SHIFT;
                        bit_cnt_reg     <= '0;
                        in_ready_reg    <= 1'b0;
                        ser_valid_reg   <= 1'b1;
                        frame_start_reg <= 1'b1;
                        frame_done_reg  <= 1'b0;
                        busy_reg        <= 1'b1;
                    end else begin
                        in_ready_reg    <= 1'b1;
                        ser_valid_reg   <= 1'b0;
                        frame_start_reg <= 1'b0;
                        frame_done_reg  <= 1'b0;
                        busy_reg        <= 1'b0;
                    end
                end

                ST_SHIFT: begin
                    if (!last_bit) begin
                        bit_cnt_reg     <= bit_cnt_inc;
                        frame_start_reg <= 1'b0;
                        frame_done_reg  <= (bit_cnt_inc == CNT_LAST);
                        // Without a gap the next word is taken during the last bit.
                        in_ready_reg    <= !HAS_GAP && (bit_cnt_inc == CNT_LAST);
                        ser_valid_reg   <= 1'b1;
                        busy_reg        <= 1'b1;
                    end else if (accept) begin
                        bit_cnt_reg     <= '0;
                        in_ready_reg    <= 1'b0;
                        ser_valid_reg   <= 1'b1;
                        frame_start_reg <= 1'b1;
                        frame_done_reg  <= 1'b0;
                        busy_reg        <= 1'b1;
                    end else if (HAS_GAP) begin
                        state_reg       <= ST_GAP;
                        bit_cnt_reg     <= '0;
                        gap_cnt_reg     <= '0;
                        in_ready_reg    <= 1'b0;
                        ser_valid_reg   <= 1'b0;
                        frame_start_reg <= 1'b0;
                        frame_done_reg  <= 1'b0;
                        busy_reg        <= 1'b1;
                    end else begin
                        state_reg       <= ST_IDLE;
                        bit_cnt_reg     <= '0;
                        in_ready_reg    <= 1'b1;
                        ser_valid_reg   <= 1'b0;
                        frame_start_reg <= 1'b0;
                        frame_done_reg  <= 1'b0;
                        busy_reg        <= 1'b0;
                    end
                end

                ST_GAP: begin
                    if (gap_cnt_reg == GAP_LAST) begin
                        state_reg    <= ST_IDLE;
                        gap_cnt_reg  <= '0;
                        in_ready_reg <= 1'b1;
                        busy_reg     <= 1'b0;
                    end else begin
                        gap_cnt_reg  <= gap_cnt_reg + GAP_CNT_W'(1);
                        in_ready_reg <= 1'b0;
                        busy_reg     <= 1'b1;
                    end
                    ser_valid_reg   <= 1'b0;
                    frame_start_reg <= 1'b0;
                    frame_done_reg  <= 1'b0;
                end

                default: begin
                    state_reg       <= ST_IDLE;
                    bit_cnt_reg     <= '0;
                    gap_cnt_reg     <= '0;
                    in_ready_reg    <= 1'b0;
                    ser_valid_reg   <= 1'b0;
                    frame_start_reg <= 1'b0;
                    frame_done_reg  <= 1'b0;
                    busy_reg        <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready    = in_ready_reg;
    assign bus.ser_q       = ser_bit;
    assign bus.ser_valid   = ser_valid_reg;
    assign bus.frame_start = frame_start_reg;
    assign bus.frame_done  = frame_done_reg;
    assign bus.busy        = busy_reg;

endmodule

// File: tb/tb_piso_tx_ctrl.sv
// Directed bench for piso_tx_ctrl: three instances cover MSB/LSB-first and
// GAP=1/GAP=0; per-cycle output vectors are compared against hand-built tables.
module tb_piso_tx_ctrl;

    logic clk;
    logic rst_n;

    piso_tx_ctrl_if #(.WIDTH(4)) bus_a ();
    piso_tx_ctrl_if #(.WIDTH(4)) bus_b ();
    piso_tx_ctrl_if #(.WIDTH(4)) bus_c ();

    piso_tx_ctrl #(.WIDTH(4), .GAP(1), .MSB_FIRST(1)) u_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
    piso_tx_ctrl #(.WIDTH(4), .GAP(1), .MSB_FIRST(0)) u_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));
    piso_tx_ctrl #(.WIDTH(4), .GAP(0), .MSB_FIRST(1)) u_c (.clk(clk), .rst_n(rst_n), .bus(bus_c));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    // Per-cycle expectation {in_ready, ser_q, ser_valid, frame_start, frame_done, busy}
    logic [5:0] exp_tbl  [16];
    logic       stim_vld [16];
    logic [3:0] stim_dat [16];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic logic [5:0] outs(input int sel);
        case (sel)
            0:       return {bus_a.in_ready, bus_a.ser_q, bus_a.ser_valid,
                             bus_a.frame_start, bus_a.frame_done, bus_a.busy};
            1:       return {bus_b.in_ready, bus_b.ser_q, bus_b.ser_valid,
                             bus_b.frame_start, bus_b.frame_done, bus_b.busy};
            default: return {bus_c.in_ready, bus_c.ser_q, bus_c.ser_valid,
                             bus_c.frame_start, bus_c.frame_done, bus_c.busy};
        endcase
    endfunction

    task automatic drive(input int sel, input logic v, input logic [3:0] d);
        case (sel)
            0:       begin bus_a.in_valid = v; bus_a.in_data = d; end
            1:       begin bus_b.in_valid = v; bus_b.in_data = d; end
            default: begin bus_c.in_valid = v; bus_c.in_data = d; end
        endcase
    endtask

    // Column vectors: leftmost of the n bits is cycle 0.
    task automatic load_exp(input int n, input logic [15:0] rdy, input logic [15:0] q,
                            input logic [15:0] vld, input logic [15:0] fs,
                            input logic [15:0] fd, input logic [15:0] bsy);
        for (int i = 0; i < n; i++)
            exp_tbl[i] = {rdy[n-1-i], q[n-1-i], vld[n-1-i], fs[n-1-i], fd[n-1-i], bsy[n-1-i]};
    endtask

    task automatic clr_stim();
        for (int i = 0; i < 16; i++) begin
            stim_vld[i] = 1'b0;
            stim_dat[i] = 4'b0000;
        end
    endtask

    // Each cycle: sample on the falling edge, compare, then drive that cycle's input.
    task automatic check_seq(input int sel, input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check($sformatf("%s_c%0d", tag, i), 32'(outs(sel)), 32'(exp_tbl[i]));
            drive(sel, stim_vld[i], stim_dat[i]);
        end
        $display("frame %s: %0d cycles checked", tag, n);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        drive(0, 1'b0, 4'b0000);
        drive(1, 1'b0, 4'b0000);
        drive(2, 1'b0, 4'b0000);

        // Reset state
        @(negedge clk);
        @(negedge clk);
        check("reset_a", 32'(outs(0)), 32'h0);
        check("reset_b", 32'(outs(1)), 32'h0);
        check("reset_c", 32'(outs(2)), 32'h0);
        rst_n = 1'b1;

        // MSB first, GAP=1, word 1011; in_data scrambled right after accept
        clr_stim();
        stim_vld[0] = 1'b1; stim_dat[0] = 4'b1011;
        stim_dat[1] = 4'b0100;
        load_exp(7, 16'b1000001, 16'b0101100, 16'b0111100,
                    16'b0100000, 16'b0000100, 16'b0111110);
        check_seq(0, "msb_1011", 7);

        // LSB first, word 1011 -> 1,1,0,1
        clr_stim();
        stim_vld[0] = 1'b1; stim_dat[0] = 4'b1011;
        load_exp(7, 16'b1000001, 16'b0110100, 16'b0111100,
                    16'b0100000, 16'b0000100, 16'b0111110);
        check_seq(1, "lsb_1011", 7);

        // GAP=0, in_valid held: 1100 then 0011 with no idle cycle between
        clr_stim();
        stim_vld[0] = 1'b1; stim_dat[0] = 4'b1100;
        for (int i = 1; i < 5; i++) begin
            stim_vld[i] = 1'b1; stim_dat[i] = 4'b0011;
        end
        load_exp(10, 16'b1000100011, 16'b0110000110, 16'b0111111110,
                     16'b0100010000, 16'b0000100010, 16'b0111111110);
        check_seq(2, "b2b_1100_0011", 10);

        // in_valid pulse with 1111 mid-frame is ignored
        clr_stim();
        stim_vld[0] = 1'b1; stim_dat[0] = 4'b0101;
        stim_vld[2] = 1'b1; stim_dat[2] = 4'b1111;
        load_exp(9, 16'b100000111, 16'b001010000, 16'b011110000,
                    16'b010000000, 16'b000010000, 16'b011111000);
        check_seq(0, "ignore_1111", 9);

        // Reset at frame bit 2 aborts immediately with no frame_done
        clr_stim();
        stim_vld[0] = 1'b1; stim_dat[0] = 4'b1011;
        load_exp(2, 16'b10, 16'b01, 16'b01, 16'b01, 16'b00, 16'b01);
        check_seq(0, "pre_abort", 2);
        @(negedge clk);
        check("abort_bit2", 32'(outs(0)), 32'h09);
        rst_n = 1'b0;
        #1;
        check("abort_now", 32'(outs(0)), 32'h0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("abort_hold%0d", i), 32'(outs(0)), 32'h0);
        end
        rst_n = 1'b1;

        clr_stim();
        stim_vld[0] = 1'b1; stim_dat[0] = 4'b0110;
        load_exp(7, 16'b1000001, 16'b0011000, 16'b0111100,
                    16'b0100000, 16'b0000100, 16'b0111110);
        check_seq(0, "post_abort_0110", 7);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
